// File: rtl/mtimer_nch.sv
// Multi-channel machine timer: prescaled 64-bit mtime plus NCH compare
// channels (one-shot or periodic) with a masked interrupt output.
module mtimer_nch #(
    parameter int NCH     = 4,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we_i,
    input  logic        csr_re_i,
    input  logic [7:0]  csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic [31:0] csr_rdata_o,
    output logic        tmr_irq_o,
    output logic        tick_o
);

    localparam logic [7:0] A_CTRL = 8'h00;
    localparam logic [7:0] A_MLO  = 8'h01;
    localparam logic [7:0] A_MHI  = 8'h02;
    localparam logic [7:0] A_PEND = 8'h03;
    localparam logic [7:0] A_IEN  = 8'h04;
    localparam logic [7:0] A_CH0  = 8'h10;
    localparam logic [5:0] NCH6   = 6'(NCH);

    logic               run;
    logic [PRESC_W-1:0] div;
    logic [PRESC_W-1:0] pc;
    logic [63:0]        mtime;
    logic [31:0]        hi_shadow;
    logic               tick_q;
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     irq_en;
    logic [NCH-1:0]     armed;
    logic [NCH-1:0]     periodic;
    logic [63:0]        cmp    [NCH];
    logic [31:0]        period [NCH];

    logic [7:0]     ch_off;
    logic [5:0]     ch_idx;
    logic [1:0]     ch_reg;
    logic           ch_hit;
    logic           hit_ctrl;
    logic           hit_mlo;
    logic           hit_mhi;
    logic           hit_pend;
    logic           hit_ien;
    logic           wr_ctrl;
    logic           wr_mlo;
    logic           wr_mhi;
    logic           wr_pend;
    logic           wr_ien;
    logic [NCH-1:0] wr_chctl;
    logic [NCH-1:0] wr_cmplo;
    logic [NCH-1:0] wr_cmphi;
    logic [NCH-1:0] wr_per;
    logic [NCH-1:0] match;
    logic [NCH-1:0] reload;
    logic [NCH-1:0] w1c;
    logic           tick_now;
    logic [31:0]    ctrl_rd;
    logic [31:0]    ch_rd;

    // Address decode: channel window starts at 0x10, 4 registers per channel.
    assign ch_off   = csr_addr_i - A_CH0;
    assign ch_idx   = ch_off[7:2];
    assign ch_reg   = ch_off[1:0];
    assign ch_hit   = (csr_addr_i >= A_CH0) && (ch_idx < NCH6);
    assign hit_ctrl = (csr_addr_i == A_CTRL);
    assign hit_mlo  = (csr_addr_i == A_MLO);
    assign hit_mhi  = (csr_addr_i == A_MHI);
    assign hit_pend = (csr_addr_i == A_PEND);
    assign hit_ien  = (csr_addr_i == A_IEN);
    assign wr_ctrl  = csr_we_i && hit_ctrl;
    assign wr_mlo   = csr_we_i && hit_mlo;
    assign wr_mhi   = csr_we_i && hit_mhi;
    assign wr_pend  = csr_we_i && hit_pend;
    assign wr_ien   = csr_we_i && hit_ien;
    assign w1c      = wr_pend ? csr_wdata_i[NCH-1:0] : '0;

    // Per-channel write strobes.
    always_comb begin
        wr_chctl = '0;
        wr_cmplo = '0;
        wr_cmphi = '0;
        wr_per   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (csr_we_i && ch_hit && (ch_idx == 6'(k))) begin
                wr_chctl[k] = (ch_reg == 2'd0);
                wr_cmplo[k] = (ch_reg == 2'd1);
                wr_cmphi[k] = (ch_reg == 2'd2);
                wr_per[k]   = (ch_reg == 2'd3);
            end
        end
    end

    // Match and reload qualification; a disarming CHCTL write kills the reload.
    always_comb begin
        match  = '0;
        reload = '0;
        for (int k = 0; k < NCH; k++) begin
            match[k]  = armed[k] && (mtime >= cmp[k]);
            reload[k] = match[k] && periodic[k] &&
                        !(wr_chctl[k] && !csr_wdata_i[0]);
        end
    end

    assign tick_now  = run && (pc == div);
    assign tmr_irq_o = |(pend & irq_en);
    assign tick_o    = tick_q;

    // Control register and interrupt enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run    <= 1'b0;
            div    <= '0;
            irq_en <= '0;
        end else begin
            if (wr_ctrl) begin
                run <= csr_wdata_i[0];
                div <= csr_wdata_i[PRESC_W+7:8];
            end
            if (wr_ien) begin
                irq_en <= csr_wdata_i[NCH-1:0];
            end
        end
    end

    // Prescaler counter; a CTRL write restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (wr_ctrl) begin
            pc <= '0;
        end else if (run) begin
            pc <= tick_now ? '0 : pc + 1'b1;
        end
    end

    // Time base; a software write to either half swallows a same-cycle tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_now && !wr_mlo && !wr_mhi;
            if (wr_mlo) begin
                mtime[31:0] <= csr_wdata_i;
            end else if (wr_mhi) begin
                mtime[63:32] <= csr_wdata_i;
            end else if (tick_now) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // High-half snapshot taken when the low half is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_shadow <= '0;
        end else if (csr_re_i && hit_mlo) begin
            hi_shadow <= mtime[63:32];
        end
    end

    // Pending bits: a hardware set wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= match | (pend & ~w1c);
        end
    end

    // Channel state: software writes win over match-clear and reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed    <= '0;
            periodic <= '0;
            for (int k = 0; k < NCH; k++) begin
                cmp[k]    <= '1;
                period[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (wr_chctl[k]) begin
                    armed[k]    <= csr_wdata_i[0];
                    periodic[k] <= csr_wdata_i[1];
                end else if (match[k] && !periodic[k]) begin
                    armed[k] <= 1'b0;
                end
                if (wr_cmplo[k]) begin
                    cmp[k][31:0] <= csr_wdata_i;
                end else if (wr_cmphi[k]) begin
                    cmp[k][63:32] <= csr_wdata_i;
                end else if (reload[k]) begin
                    cmp[k] <= cmp[k] + {32'h0, period[k]};
                end
                if (wr_per[k]) begin
                    period[k] <= csr_wdata_i;
                end
            end
        end
    end

    // Channel register readback.
    always_comb begin
        ch_rd = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch_idx == 6'(k)) begin
                case (ch_reg)
                    2'd0:    ch_rd = {30'b0, periodic[k], armed[k]};
                    2'd1:    ch_rd = cmp[k][31:0];
                    2'd2:    ch_rd = cmp[k][63:32];
                    default: ch_rd = period[k];
                endcase
            end
        end
    end

    // CTRL readback image.
    always_comb begin
        ctrl_rd               = '0;
        ctrl_rd[0]            = run;
        ctrl_rd[PRESC_W+7:8]  = div;
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        csr_rdata_o = '0;
        unique case (1'b1)
            hit_ctrl: csr_rdata_o = ctrl_rd;
            hit_mlo:  csr_rdata_o = mtime[31:0];
            hit_mhi:  csr_rdata_o = hi_shadow;
            hit_pend: csr_rdata_o = 32'(pend);
            hit_ien:  csr_rdata_o = 32'(irq_en);
            ch_hit:   csr_rdata_o = ch_rd;
            default:  csr_rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_mtimer_nch.sv
// Scoreboard bench for mtimer_nch: expected values are queued with the
// stimulus and popped when the DUT output is sampled.
module tb_mtimer_nch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csr_we = 1'b0;
    logic        csr_re = 1'b0;
    logic [7:0]  csr_addr = 8'h00;
    logic [31:0] csr_wdata = 32'h0;
    logic [31:0] csr_rdata;
    logic        tmr_irq;
    logic        tick;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] ex;

    mtimer_nch #(.NCH(4), .PRESC_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .csr_we_i    (csr_we),
        .csr_re_i    (csr_re),
        .csr_addr_i  (csr_addr),
        .csr_wdata_i (csr_wdata),
        .csr_rdata_o (csr_rdata),
        .tmr_irq_o   (tmr_irq),
        .tick_o      (tick)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        csr_addr = a;
        #1;
        d = csr_rdata;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] addrs [5];
        addrs = '{8'h00, 8'h01, 8'h11, 8'h1E, 8'h1F};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex)
            $display("FAIL reset_irq got=%h exp=%h", tmr_irq, ex);
        else passed++;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tick} !== ex)
            $display("FAIL reset_tick got=%h exp=%h", tick, ex);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd(addrs[i], got);
            ex = exp_q.pop_front();
            checks++;
            if (got !== ex)
                $display("FAIL reset_reg[%h] got=%h exp=%h", addrs[i], got, ex);
            else passed++;
        end
    endtask

    task automatic test_default_run();
        wr(8'h00, 32'h1);
        cyc(5);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        rd(8'h01, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL run_mtime got=%h exp=%h", got, ex);
        else passed++;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tick} !== ex) $display("FAIL run_tick got=%h exp=%h", tick, ex);
        else passed++;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex) $display("FAIL run_irq got=%h exp=%h", tmr_irq, ex);
        else passed++;
    endtask

    task automatic test_prescaler();
        wr(8'h00, 32'h0);
        wr(8'h01, 32'h0);
        wr(8'h02, 32'h0);
        wr(8'h00, 32'h301);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            exp_q.push_back({31'b0, (i % 4) == 0});
            ex = exp_q.pop_front();
            checks++;
            if ({31'b0, tick} !== ex)
                $display("FAIL presc_tick[%0d] got=%h exp=%h", i, tick, ex);
            else passed++;
        end
        exp_q.push_back(32'd3);
        rd(8'h01, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL presc_mtime got=%h exp=%h", got, ex);
        else passed++;
        cyc(2);
        wr(8'h00, 32'h301);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            exp_q.push_back({31'b0, j == 4});
            ex = exp_q.pop_front();
            checks++;
            if ({31'b0, tick} !== ex)
                $display("FAIL presc_restart[%0d] got=%h exp=%h", j, tick, ex);
            else passed++;
        end
        exp_q.push_back(32'd4);
        rd(8'h01, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL presc_mtime2 got=%h exp=%h", got, ex);
        else passed++;
    endtask

    task automatic test_oneshot();
        wr(8'h00, 32'h0);
        wr(8'h01, 32'h1C);
        wr(8'h02, 32'h0);
        wr(8'h11, 32'h20);
        wr(8'h12, 32'h0);
        wr(8'h04, 32'h1);
        wr(8'h10, 32'h1);
        wr(8'h00, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            exp_q.push_back({31'b0, i >= 5});
            ex = exp_q.pop_front();
            checks++;
            if ({31'b0, tmr_irq} !== ex)
                $display("FAIL os_irq[%0d] got=%h exp=%h", i, tmr_irq, ex);
            else passed++;
            if (i == 4) begin
                exp_q.push_back(32'h20);
                rd(8'h01, got);
                ex = exp_q.pop_front();
                checks++;
                if (got !== ex) $display("FAIL os_mtime got=%h exp=%h", got, ex);
                else passed++;
            end
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        rd(8'h10, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL os_armed got=%h exp=%h", got, ex);
        else passed++;
        rd(8'h03, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL os_pend got=%h exp=%h", got, ex);
        else passed++;
        wr(8'h03, 32'h1);
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex) $display("FAIL os_w1c got=%h exp=%h", tmr_irq, ex);
        else passed++;
        cyc(3);
        exp_q.push_back(32'h0);
        rd(8'h03, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL os_refire got=%h exp=%h", got, ex);
        else passed++;
    endtask

    task automatic test_periodic();
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h4);
        wr(8'h01, 32'h0C);
        wr(8'h02, 32'h0);
        wr(8'h19, 32'h10);
        wr(8'h1A, 32'h0);
        wr(8'h1B, 32'h8);
        wr(8'h18, 32'h3);
        wr(8'h00, 32'h1);
        for (int i = 1; i <= 22; i++) begin
            if (i == 8 || i == 13 || i == 16) begin
                csr_we    = 1'b1;
                csr_addr  = 8'h03;
                csr_wdata = 32'h4;
            end
            exp_q.push_back({31'b0, (i >= 5 && i <= 7) ||
                                    (i >= 13 && i <= 15) || (i >= 21)});
            @(negedge clk);
            csr_we = 1'b0;
            ex = exp_q.pop_front();
            checks++;
            if ({31'b0, tmr_irq} !== ex)
                $display("FAIL per_irq[%0d] got=%h exp=%h", i, tmr_irq, ex);
            else passed++;
        end
        exp_q.push_back(32'h28);
        exp_q.push_back(32'h3);
        rd(8'h19, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL per_cmp got=%h exp=%h", got, ex);
        else passed++;
        rd(8'h18, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL per_chctl got=%h exp=%h", got, ex);
        else passed++;
        wr(8'h18, 32'h0);
        wr(8'h03, 32'hF);
    endtask

    task automatic test_snapshot();
        wr(8'h00, 32'h0);
        wr(8'h02, 32'h0);
        wr(8'h01, 32'hFFFF_FFFE);
        wr(8'h00, 32'h1);
        cyc(1);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h1);
        csr_addr = 8'h01;
        csr_re   = 1'b1;
        #1;
        got = csr_rdata;
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL snap_lo got=%h exp=%h", got, ex);
        else passed++;
        @(negedge clk);
        csr_re = 1'b0;
        cyc(1);
        rd(8'h02, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL snap_hi got=%h exp=%h", got, ex);
        else passed++;
        rd(8'h01, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL snap_lo2 got=%h exp=%h", got, ex);
        else passed++;
        csr_addr = 8'h01;
        csr_re   = 1'b1;
        @(negedge clk);
        csr_re = 1'b0;
        rd(8'h02, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL snap_hi2 got=%h exp=%h", got, ex);
        else passed++;
    endtask

    task automatic test_wrap();
        wr(8'h00, 32'h0);
        wr(8'h02, 32'hFFFF_FFFF);
        wr(8'h01, 32'hFFFF_FFFF);
        wr(8'h00, 32'h1);
        cyc(1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        rd(8'h01, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL wrap_lo got=%h exp=%h", got, ex);
        else passed++;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tick} !== ex) $display("FAIL wrap_tick got=%h exp=%h", tick, ex);
        else passed++;
        csr_addr = 8'h01;
        csr_re   = 1'b1;
        @(negedge clk);
        csr_re = 1'b0;
        rd(8'h02, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL wrap_hi got=%h exp=%h", got, ex);
        else passed++;
    endtask

    task automatic test_unmapped();
        logic [7:0] addrs [4];
        addrs = '{8'h21, 8'h05, 8'h11, 8'h04};
        wr(8'h00, 32'h0);
        wr(8'h21, 32'h1234_5678);
        wr(8'h05, 32'hFFFF_FFFF);
        wr(8'h50, 32'h0000_AAAA);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd(addrs[i], got);
            ex = exp_q.pop_front();
            checks++;
            if (got !== ex)
                $display("FAIL unmapped[%h] got=%h exp=%h", addrs[i], got, ex);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        wr(8'h00, 32'h0);
        wr(8'h04, 32'h2);
        wr(8'h15, 32'h0);
        wr(8'h16, 32'h0);
        wr(8'h14, 32'h1);
        cyc(1);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex) $display("FAIL mid_irq_pre got=%h exp=%h", tmr_irq, ex);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex) $display("FAIL mid_irq_async got=%h exp=%h", tmr_irq, ex);
        else passed++;
        rd(8'h03, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL mid_pend got=%h exp=%h", got, ex);
        else passed++;
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        rd(8'h15, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL mid_cmp1 got=%h exp=%h", got, ex);
        else passed++;
        rd(8'h14, got);
        ex = exp_q.pop_front();
        checks++;
        if (got !== ex) $display("FAIL mid_armed got=%h exp=%h", got, ex);
        else passed++;
        ex = exp_q.pop_front();
        checks++;
        if ({31'b0, tmr_irq} !== ex) $display("FAIL mid_irq_post got=%h exp=%h", tmr_irq, ex);
        else passed++;
    endtask

    initial begin
        cyc(2);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_default_run();
        test_prescaler();
        test_oneshot();
        test_periodic();
        test_snapshot();
        test_wrap();
        test_unmapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
